uarc_send_arbiter: RTL
======================

# uarc_send_arbiter

Receive-side scheduler for UARC `send` traffic into core0. It watches every bus's incoming `send` request and gates each one through a software-written enable mask. It picks one winner, acknowledges that bus, latches the bus index and data word, and presents them to the core's interrupt logic through a valid/ready handshake. It replaces the purely combinational priority-encoder choice with a registered, fair, handshaked grant.

## Interface
Parameters:
- `WORD_MAG`, 5, log2 of word width; `WORD_WIDTH = 1 << WORD_MAG`.
- `TOTAL_BUSES`, 4, number of receiver buses; must satisfy 1 ≤ `TOTAL_BUSES` ≤ 2^`WORD_WIDTH`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `receiver_sends`  in  `TOTAL_BUSES`  per-bus send request; held high by the sender until acknowledged.
- `receiver_datas`  in  `[TOTAL_BUSES][WORD_WIDTH]`  per-bus send data word.
- `receiver_send_acks`  out  `TOTAL_BUSES`  one-cycle ack pulse to the granted bus.
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_value`  in  `TOTAL_BUSES`  new mask value; bit i set means bus i may be granted.
- `mask`  out  `TOTAL_BUSES`  current enable mask register.
- `int_valid`  out  1  a latched send is pending for the core.
- `int_bus`  out  `WORD_WIDTH`  index of the granted bus, zero-extended.
- `int_data`  out  `WORD_WIDTH`  data word latched from the granted bus.
- `int_ready`  in  1  core accepts the pending send (ignored while `int_valid`=0).

## Operation
- The FSM has two states, IDLE and PENDING.
- Masked request: `req[i] = receiver_sends[i] & mask[i]`. It uses the registered mask, never `mask_value`.
- In IDLE, when any `req` bit is set at a rising edge:
  - Select the winner `w`.
  - Register `int_bus = w` and `int_data = receiver_datas[w]`.
  - Set `receiver_send_acks[w]` for the following cycle only.
  - Assert `int_valid` and go to PENDING.
- In IDLE with no `req` bit set, nothing changes.
- In PENDING, `receiver_sends` is ignored and no further ack is issued.
- In PENDING, when `int_valid & int_ready` at a rising edge, go to IDLE and deassert `int_valid`.
  - `int_bus` and `int_data` hold their last values; they are not cleared.
- Mask write: on `mask_we`, `mask <= mask_value` at the edge, in either state.
  - A pending grant is never cancelled by a mask write.
  - When the write coincides with selection in IDLE, selection uses the old mask.
- At most one bit of `receiver_send_acks` is ever high, and only in the first cycle of PENDING.
- Winner selection is governed by `UARC_SEND_RR_EN` (see Configuration).
- Reset (async, `reset`=0): state IDLE, `receiver_send_acks`=0, `int_valid`=0, `int_bus`=0, `int_data`=0, `mask`=0 (all buses disabled), round-robin pointer=0.
  - If reset is asserted mid-PENDING, the pending send is dropped without being delivered to the core.

## Timing
- Request sampled at edge N: ack is high during cycle N+1 and `int_valid` rises in cycle N+1.
- The sender drops `send` at the edge ending its ack cycle. The arbiter is still in PENDING then, so a stale request is never re-granted.
- Minimum PENDING duration is 1 cycle, when `int_ready`=1 in the ack cycle.
- The earliest next grant is 2 cycles after the previous grant, which gives a peak throughput of 1 send per 2 cycles.
- The `int_*` outputs are stable throughout PENDING.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `UARC_SEND_RR_EN` defined: round-robin selection.
  - Search starts at the pointer `p` and runs upward, wrapping at `TOTAL_BUSES`; the first set `req` bit wins.
  - On grant, `p <= (w+1) mod TOTAL_BUSES`.
  - The pointer is `max(1, $clog2(TOTAL_BUSES))` bits wide.
- `UARC_SEND_RR_EN` undefined: fixed priority, where the lowest-index set `req` bit wins.
  - No pointer register exists.

## Test plan
- Reset and mask gating: `TOTAL_BUSES`=4, mask=0, `receiver_sends`=4'b1111 → no ack and `int_valid`=0 for 10 cycles. Write mask=4'b0100 → ack on bus 2 exactly one cycle later, `int_bus`=2, `int_data`=bus 2 data.
- Latency and handshake: mask=4'b1111, bus 1 sends 32'hDEADBEEF at edge N, `int_ready` held 0 → `receiver_send_acks`=4'b0010 only in cycle N+1, `int_valid` stays high with data 32'hDEADBEEF until `int_ready`=1, then falls on the next cycle.
- Fairness (RR_EN): all four buses send continuously and re-raise after ack, `int_ready`=1 → grant order 0,1,2,3,0. Without RR_EN the same stimulus grants bus 0 every time.
- Wrap-around: pointer=3 after granting bus 2, requests on buses 0 and 1 only → bus 0 granted, pointer becomes 1.
- Mask write during PENDING: grant pending on bus 3, write mask=0 → `int_valid` stays high, delivery completes, no further grants.
- Async reset mid-PENDING: `reset` driven low asynchronously → `int_valid`, acks, `int_bus`, `int_data` and `mask` all become 0 immediately, before any clock edge, and the FSM returns to IDLE.

Source files
------------

// File: rtl/uarc_send_arbiter_if.sv
// uarc_send_arbiter_if: request/ack bus, enable-mask port and core-side
// valid/ready handshake of the UARC send arbiter, bundled for one connection.
// The arbiter takes the slave modport. The sender/core side takes the master modport.
interface uarc_send_arbiter_if #(
   parameter int WORD_MAG    = 5,
   parameter int TOTAL_BUSES = 4
);
   localparam int WORD_WIDTH = 1 << WORD_MAG;

   logic [TOTAL_BUSES-1:0]                 receiver_sends;
   logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
   logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
   logic                                   mask_we;
   logic [TOTAL_BUSES-1:0]                 mask_value;
   logic [TOTAL_BUSES-1:0]                 mask;
   logic                                   int_valid;
   logic [WORD_WIDTH-1:0]                  int_bus;
   logic [WORD_WIDTH-1:0]                  int_data;
   logic                                   int_ready;

   modport master (
      output receiver_sends, receiver_datas, mask_we, mask_value, int_ready,
      input  receiver_send_acks, mask, int_valid, int_bus, int_data
   );

   modport slave (
      input  receiver_sends, receiver_datas, mask_we, mask_value, int_ready,
      output receiver_send_acks, mask, int_valid, int_bus, int_data
   );
endinterface

// File: rtl/uarc_send_arbiter.sv
// uarc_send_arbiter: receive-side scheduler for UARC send traffic into core0.
// Each bus request is gated by a software-written enable mask. The arbiter
// grants one bus, acks it for one cycle, and latches the bus index and data word.
// The latched send is then held for the core behind a valid/ready handshake.
// Configuration macro UARC_SEND_RR_EN: defined selects round-robin winner
// selection with a wrap-around pointer. Undefined selects fixed priority,
// where the lowest index wins.
module uarc_send_arbiter #(
   parameter int WORD_MAG    = 5,
   parameter int TOTAL_BUSES = 4
) (
   input logic                 clk,
   input logic                 reset,
   uarc_send_arbiter_if.slave  bus
);
   localparam int WORD_WIDTH = 1 << WORD_MAG;
   localparam int IDX_W      = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

   typedef enum logic {IDLE, PENDING} state_t;

   state_t                 state_q;
   logic [TOTAL_BUSES-1:0] mask_q;
   logic [TOTAL_BUSES-1:0] acks_q;
   logic                   int_valid_q;
   logic [WORD_WIDTH-1:0]  int_bus_q;
   logic [WORD_WIDTH-1:0]  int_data_q;

   logic [TOTAL_BUSES-1:0] req;
   logic                   grant_any;
   logic [IDX_W-1:0]       grant_idx;

   // Requests only count for buses enabled in the registered mask.
   assign req = bus.receiver_sends & mask_q;

`ifdef UARC_SEND_RR_EN
   logic [IDX_W-1:0] ptr_q;

   // Round-robin search: scan upward from the pointer with wrap; the smallest offset wins.
   always_comb begin
      int               pos;
      logic [IDX_W-1:0] pos_idx;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      grant_any = 1'b0;
      grant_idx = '0;
      pos       = 0;
      pos_idx   = '0;
      for (int k = TOTAL_BUSES - 1; k >= 0; k--) begin
         pos = int'(ptr_q) + k;
         if (pos >= TOTAL_BUSES) pos = pos - TOTAL_BUSES;
         pos_idx = IDX_W'(pos);
         if (req[pos_idx]) begin
            grant_any = 1'b1;
            grant_idx = pos_idx;
         end
      end
   end
`else
   // Fixed priority: scanning downward leaves the lowest-index request as the winner.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = TOTAL_BUSES - 1; k >= 0; k--) begin
         if (req[IDX_W'(k)]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(k);
         end
      end
   end
`endif

   // Grant FSM with registered outputs. The mask write is independent of state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         acks_q      <= '0;
         int_valid_q <= 1'b0;
         int_bus_q   <= '0;
         int_data_q  <= '0;
`ifdef UARC_SEND_RR_EN
         ptr_q       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so the default below and the per-bus set later resolve last-wins.
         acks_q <= '0;
         // Selection this cycle already used the old mask through req.
         if (bus.mask_we) mask_q <= bus.mask_value;
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  state_q           <= PENDING;
                  int_valid_q       <= 1'b1;
                  int_bus_q         <= WORD_WIDTH'(grant_idx);
                  int_data_q        <= bus.receiver_datas[grant_idx];
                  acks_q[grant_idx] <= 1'b1;
`ifdef UARC_SEND_RR_EN
                  ptr_q <= (grant_idx == IDX_W'(TOTAL_BUSES - 1)) ? '0
                                                                  : grant_idx + IDX_W'(1);
`endif
               end
            end
            PENDING: begin
               // Senders are ignored here, so a request still held through the ack cycle is not re-granted.
               if (bus.int_ready) begin
                  state_q     <= IDLE;
                  int_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.receiver_send_acks = acks_q;
   assign bus.mask               = mask_q;
   assign bus.int_valid          = int_valid_q;
   assign bus.int_bus            = int_bus_q;
   assign bus.int_data           = int_data_q;
endmodule
